// File: rtl/mem_readout.sv
// mem_readout: streams a contiguous noun-memory region off-chip as MSB-first bytes over valid/ready.
`ifndef MEMORY_ADDR_WIDTH
`define MEMORY_ADDR_WIDTH 8
`endif
`ifndef MEMORY_DATA_WIDTH
`define MEMORY_DATA_WIDTH 64
`endif
module mem_readout #(
  parameter int ADDR_W = `MEMORY_ADDR_WIDTH,
  parameter int DATA_W = `MEMORY_DATA_WIDTH,
  parameter logic [1:0] MEM_FUNC_READ = 2'b00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   word_count,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] read_data,
  output logic              mem_execute,
  output logic [1:0]        mem_func,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] write_data,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              finished
);
  localparam int BYTES_PER_WORD = DATA_W / 8;
  localparam int BI_W = BYTES_PER_WORD > 1 ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [2:0] S_IDLE = 3'd0, S_REQ = 3'd1, S_WAIT_BUSY = 3'd2, S_WAIT_DONE = 3'd3,
                         S_SHIFT = 3'd4, S_DONE = 3'd5;
`ifdef READOUT_CHECKSUM_EN
  localparam logic [2:0] S_CSUM = 3'd6;
  localparam logic [2:0] S_END = S_CSUM;
`else
  localparam logic [2:0] S_END = S_DONE;
`endif

  if (DATA_W % 8 != 0) begin : g_bad_width
    $error("mem_readout: DATA_W must be a multiple of 8");
  end

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_remain;
  logic [DATA_W-1:0] r_shreg;
  logic [BI_W-1:0]   r_idx;
  logic [7:0]        w_byte;
`ifdef READOUT_CHECKSUM_EN
  logic [7:0]        r_csum;
`endif

  assign w_byte = r_shreg[{r_idx, 3'b000} +: 8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_remain <= '0;
      r_shreg  <= '0;
      r_idx    <= '0;
`ifdef READOUT_CHECKSUM_EN
      r_csum   <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_DONE: if (start) begin
          r_addr   <= start_addr;
          r_remain <= word_count;
          r_state  <= (word_count == '0) ? S_END : S_REQ;
`ifdef READOUT_CHECKSUM_EN
          r_csum   <= '0;
`endif
        end
        S_REQ:       if (mem_ready) r_state <= S_WAIT_BUSY;
        S_WAIT_BUSY: if (!mem_ready) r_state <= S_WAIT_DONE;
        S_WAIT_DONE: if (mem_ready) begin
          r_shreg <= read_data;
          r_idx   <= BI_W'(BYTES_PER_WORD - 1);
          r_state <= S_SHIFT;
        end
        S_SHIFT: if (out_ready) begin
`ifdef READOUT_CHECKSUM_EN
          r_csum <= r_csum ^ w_byte;
`endif
          if (r_idx == '0) begin
            r_remain <= r_remain - (ADDR_W+1)'(1);
            r_addr   <= r_addr + ADDR_W'(1);
            r_state  <= (r_remain == (ADDR_W+1)'(1)) ? S_END : S_REQ;
          end else begin
            r_idx <= r_idx - BI_W'(1);
          end
        end
`ifdef READOUT_CHECKSUM_EN
        S_CSUM: if (out_ready) r_state <= S_DONE;
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_execute = (r_state == S_REQ) && mem_ready;
    mem_func    = MEM_FUNC_READ;
    address     = r_addr;
    write_data  = '0;
    busy        = (r_state != S_IDLE) && (r_state != S_DONE);
    finished    = (r_state == S_DONE);
`ifdef READOUT_CHECKSUM_EN
    out_valid   = (r_state == S_SHIFT) || (r_state == S_CSUM);
    out_data    = (r_state == S_SHIFT) ? w_byte : (r_state == S_CSUM) ? r_csum : 8'h00;
`else
    out_valid   = (r_state == S_SHIFT);
    out_data    = (r_state == S_SHIFT) ? w_byte : 8'h00;
`endif
  end
endmodule

// File: tb/tb_mem_readout.sv
// tb_mem_readout: directed self-checking bench for mem_readout with a latency-2 memory model.
module tb_mem_readout;
  localparam int AW = 8, DW = 64, BPW = 8, LAT = 2;
  logic clk = 0, rst = 1, start = 0, out_ready = 1, mem_ready = 1;
  logic [AW-1:0] start_addr = '0;
  logic [AW:0] word_count = '0;
  logic [DW-1:0] read_data = '0;
  logic mem_execute, out_valid, busy, finished;
  logic [1:0] mem_func;
  logic [AW-1:0] address;
  logic [DW-1:0] write_data;
  logic [7:0] out_data;
  int n_pass = 0, n_chk = 0;
  logic [DW-1:0] mem [0:255];
  logic [AW-1:0] exec_q[$];
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int lat_cnt = 0;
  logic pend = 0;
  logic [AW-1:0] m_addr = '0;

  mem_readout #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .word_count(word_count),
    .mem_ready(mem_ready), .read_data(read_data), .mem_execute(mem_execute), .mem_func(mem_func),
    .address(address), .write_data(write_data), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .finished(finished));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_execute) begin
      exec_q.push_back(address);
      m_addr <= address;
      lat_cnt <= LAT;
      mem_ready <= 1'b0;
      pend <= 1'b1;
    end else if (pend) begin
      if (lat_cnt == 0) begin
        mem_ready <= 1'b1;
        read_data <= mem[m_addr];
        pend <= 1'b0;
      end else lat_cnt <= lat_cnt - 1;
    end
  end

  always @(posedge clk) if (out_valid && out_ready) got_q.push_back(out_data);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    exec_q.delete();
    got_q.delete();
  endtask

  task automatic build_exp(input logic [AW-1:0] a, input int c);
    logic [7:0] cs, b;
    logic [AW-1:0] aa;
    exp_q.delete();
    cs = 8'h00;
    for (int w = 0; w < c; w++) begin
      aa = a + AW'(w);
      for (int k = BPW - 1; k >= 0; k--) begin
        b = mem[aa][8*k +: 8];
        exp_q.push_back(b);
        cs = cs ^ b;
      end
    end
`ifdef READOUT_CHECKSUM_EN
    exp_q.push_back(cs);
`endif
  endtask

  function automatic int byte_errs();
    int e;
    e = (got_q.size() != exp_q.size()) ? 1 : 0;
    foreach (exp_q[i]) if (i >= got_q.size() || got_q[i] !== exp_q[i]) e++;
    return e;
  endfunction

  task automatic pulse_start(input logic [AW-1:0] a, input logic [AW:0] c);
    start_addr = a;
    word_count = c;
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic wait_fin(input string name, input int max);
    int i;
    i = 0;
    while (!finished && i < max) begin
      tick();
      i++;
    end
    n_chk++;
    if (finished !== 1'b1) $display("FAIL %s finished: got %b want 1 after %0d cycles", name, finished, i);
    else n_pass++;
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_chk++;
    if ({mem_execute, out_valid, busy, finished} !== 4'b0) $display("FAIL reset ctrl: got %b want 0000", {mem_execute, out_valid, busy, finished});
    else n_pass++;
    n_chk++;
    if (address !== 8'h00 || out_data !== 8'h00) $display("FAIL reset addr/data: got %h/%h want 00/00", address, out_data);
    else n_pass++;
    n_chk++;
    if (write_data !== 64'h0 || mem_func !== 2'b00) $display("FAIL reset wdata/func: got %h/%b want 0/00", write_data, mem_func);
    else n_pass++;
    rst = 0;
    tick();
  endtask

  task automatic test_single();
    clear_q();
    build_exp(8'd1, 1);
    pulse_start(8'd1, 9'd1);
    n_chk++;
    if (busy !== 1'b1 || finished !== 1'b0) $display("FAIL single busy/fin after start: got %b/%b want 1/0", busy, finished);
    else n_pass++;
    wait_fin("single", 200);
    n_chk++;
    if (exec_q.size() != 1 || exec_q[0] !== 8'd1) $display("FAIL single exec: got %0d reqs first %h want 1 req at 01", exec_q.size(), exec_q.size() ? exec_q[0] : 8'hxx);
    else n_pass++;
    n_chk++;
    if (got_q.size() < 8 || got_q[0] !== 8'h01 || got_q[7] !== 8'hEF) $display("FAIL single order: got %0d bytes first %h want first 01 eighth EF", got_q.size(), got_q.size() ? got_q[0] : 8'hxx);
    else n_pass++;
    n_chk++;
    if (byte_errs() != 0) $display("FAIL single bytes: got %0d errors over %0d bytes want 0", byte_errs(), got_q.size());
    else n_pass++;
`ifdef READOUT_CHECKSUM_EN
    n_chk++;
    if (got_q.size() != 9 || got_q[8] !== 8'h00) $display("FAIL single csum: got %0d bytes want 9 with last 00", got_q.size());
    else n_pass++;
`endif
    n_chk++;
    if (busy !== 1'b0) $display("FAIL single busy at done: got %b want 0", busy);
    else n_pass++;
  endtask

  task automatic test_wrap();
    clear_q();
    build_exp(8'd255, 2);
    pulse_start(8'd255, 9'd2);
    wait_fin("wrap", 300);
    n_chk++;
    if (exec_q.size() != 2 || exec_q[0] !== 8'd255 || exec_q[1] !== 8'd0) $display("FAIL wrap exec: got %0d reqs want 2 at ff,00", exec_q.size());
    else n_pass++;
    n_chk++;
    if (byte_errs() != 0) $display("FAIL wrap bytes: got %0d errors over %0d bytes want 0", byte_errs(), got_q.size());
    else n_pass++;
  endtask

  task automatic test_stall();
    logic pat [4];
    logic pv, pr;
    logic [7:0] pd;
    int viol, k;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    viol = 0;
    k = 0;
    clear_q();
    build_exp(8'd10, 3);
    pulse_start(8'd10, 9'd3);
    while (!finished && k < 600) begin
      out_ready = pat[k % 4];
      pv = out_valid;
      pr = out_ready;
      pd = out_data;
      tick();
      if (pv && !pr && (out_valid !== 1'b1 || out_data !== pd)) viol++;
      k++;
    end
    out_ready = 1;
    n_chk++;
    if (finished !== 1'b1) $display("FAIL stall finished: got %b want 1", finished);
    else n_pass++;
    n_chk++;
    if (viol != 0) $display("FAIL stall stability: got %0d violations want 0", viol);
    else n_pass++;
    n_chk++;
    if (byte_errs() != 0) $display("FAIL stall bytes: got %0d errors over %0d bytes want 0", byte_errs(), got_q.size());
    else n_pass++;
  endtask

  task automatic test_zero();
    clear_q();
    build_exp(8'd5, 0);
    pulse_start(8'd5, 9'd0);
`ifdef READOUT_CHECKSUM_EN
    wait_fin("zero", 20);
`else
    wait_fin("zero", 2);
`endif
    n_chk++;
    if (exec_q.size() != 0) $display("FAIL zero exec: got %0d reqs want 0", exec_q.size());
    else n_pass++;
    n_chk++;
    if (byte_errs() != 0) $display("FAIL zero bytes: got %0d bytes want %0d", got_q.size(), exp_q.size());
    else n_pass++;
  endtask

  task automatic test_busy_start();
    clear_q();
    build_exp(8'd20, 2);
    pulse_start(8'd20, 9'd2);
    tick();
    tick();
    tick();
    pulse_start(8'd50, 9'd1);
    wait_fin("busy_start", 300);
    n_chk++;
    if (exec_q.size() != 2 || exec_q[0] !== 8'd20 || exec_q[1] !== 8'd21) $display("FAIL busy_start exec: got %0d reqs want 2 at 14,15", exec_q.size());
    else n_pass++;
    n_chk++;
    if (byte_errs() != 0) $display("FAIL busy_start bytes: got %0d errors over %0d bytes want 0", byte_errs(), got_q.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int k, ne, nb;
    k = 0;
    clear_q();
    pulse_start(8'd30, 9'd5);
    while (!(exec_q.size() == 3 && out_valid) && k < 500) begin
      tick();
      k++;
    end
    tick();
    n_chk++;
    if (out_valid !== 1'b1 || exec_q.size() != 3) $display("FAIL rst_mid reach shift: got valid %b reqs %0d want 1/3", out_valid, exec_q.size());
    else n_pass++;
    rst = 1;
    #1;
    n_chk++;
    if ({mem_execute, out_valid, busy, finished} !== 4'b0 || address !== 8'h00 || out_data !== 8'h00) $display("FAIL rst_mid outputs: got %b addr %h data %h want 0000/00/00", {mem_execute, out_valid, busy, finished}, address, out_data);
    else n_pass++;
    ne = exec_q.size();
    nb = got_q.size();
    for (int i = 0; i < 5; i++) tick();
    rst = 0;
    for (int i = 0; i < 10; i++) tick();
    n_chk++;
    if (exec_q.size() != ne || got_q.size() != nb || busy !== 1'b0) $display("FAIL rst_mid quiet: got reqs %0d bytes %0d busy %b want %0d/%0d/0", exec_q.size(), got_q.size(), busy, ne, nb);
    else n_pass++;
    clear_q();
    build_exp(8'd40, 1);
    pulse_start(8'd40, 9'd1);
    wait_fin("rst_mid restart", 200);
    n_chk++;
    if (exec_q.size() != 1 || exec_q[0] !== 8'd40) $display("FAIL rst_mid restart exec: got %0d reqs want 1 at 28", exec_q.size());
    else n_pass++;
    n_chk++;
    if (byte_errs() != 0) $display("FAIL rst_mid restart bytes: got %0d errors over %0d bytes want 0", byte_errs(), got_q.size());
    else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      logic [7:0] b;
      b = i[7:0];
      mem[i] = {b, ~b, 8'h5A, b ^ 8'h3C, 8'hC3, b + 8'd1, 8'h96, b};
    end
    mem[1] = 64'h0123456789ABCDEF;
    test_reset();
    test_single();
    test_wrap();
    test_stall();
    test_zero();
    test_busy_start();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
